dsp_cmd_sequencer: RTL and testbench

- Initiator for the DSP slice. Accepts MAC-style commands over a valid/ready interface and drives the DSP data, opmode, clock-enable and reset pins.
- Tracks the DSP pipeline latency with a tag/valid shift register and returns the 48-bit results in order over a valid/ready interface.
- Handles backpressure by freezing the DSP through its clock enables.

---
 rtl/dsp_seq_pkg.sv | 48 ++++
 rtl/dsp_seq_delay.sv | 40 ++++
 rtl/dsp_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_dsp_cmd_sequencer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dsp_seq_pkg
// Description : Shared definitions for the DSP command sequencer: command
//               op encodings, DSP opmode constants, FSM state encoding and
//               the op-to-opmode mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_seq_pkg;

    // Command op encodings as presented on cmd_op
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MAC    = 2'd1;
    localparam logic [1:0] OP_PREMUL = 2'd2;
    localparam logic [1:0] OP_MULADD = 2'd3;

    // DSP opmode words; X select in [1:0], Z select in [3:2], pre-adder in [4]
    localparam logic [7:0] OPMODE_MUL    = 8'b0000_0001;  // P = A*B
    localparam logic [7:0] OPMODE_MAC    = 8'b0000_1001;  // P = P + A*B
    localparam logic [7:0] OPMODE_PREMUL = 8'b0001_0001;  // P = (D+B)*A
    localparam logic [7:0] OPMODE_MULADD = 8'b0000_1101;  // P = C + A*B
    localparam logic [7:0] OPMODE_BUBBLE = 8'b0000_1000;  // P = P (hold)

    // Post-adder subtract: Z - (X + CIN)
    localparam int unsigned OPMODE_SUB_BIT = 7;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } seq_state_e;

    // Translate a command op plus subtract flag into the DSP opmode word
    function automatic logic [7:0] op_to_opmode(input logic [1:0] op, input logic sub);
        logic [7:0] opm;
        case (op)
            OP_MUL:    opm = OPMODE_MUL;
            OP_MAC:    opm = OPMODE_MAC;
            OP_PREMUL: opm = OPMODE_PREMUL;
            default:   opm = OPMODE_MULADD;
        endcase
        opm[OPMODE_SUB_BIT] = sub;
        return opm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_seq_delay.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_delay
// Description : Width/depth parameterised shift register with a common
//               advance enable and synchronous clear. Used to align opmode/C
//               with the multiplier stage and to track valid/tag through the
//               DSP pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_seq_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enabled cycle; hold every stage when disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dsp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_cmd_sequencer
// Description : Command initiator for a DSP slice. Accepts MAC-style commands
//               over valid/ready, drives DSP data/opmode/CE/RST pins, tracks
//               pipeline latency with a valid/tag shift register and returns
//               results in order over valid/ready. Output backpressure
//               freezes the DSP through its clock enables.
// Options     : DSP_SEQ_STATS_EN adds saturating stat_results/stat_stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_cmd_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LAT       = 3,
    parameter int ALIGN_DLY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_sub,
    input  logic [17:0]      cmd_a,
    input  logic [17:0]      cmd_b,
    input  logic [17:0]      cmd_d,
    input  logic [47:0]      cmd_c,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [17:0]      dsp_D,
    output logic [47:0]      dsp_C,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_CARRYIN,
    output logic             dsp_CE,
    output logic             dsp_RST,
    input  logic [47:0]      dsp_P,
    input  logic             dsp_CARRYOUT,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_p,
    output logic             res_carry,
    output logic [TAG_W-1:0] res_tag
`ifdef DSP_SEQ_STATS_EN
   ,output logic [15:0]      stat_results,
    output logic [15:0]      stat_stalls
`endif
);

    localparam int PIPE_W  = TAG_W + 1;
    localparam int ALIGN_W = 8 + 48;

    seq_state_e       state_q;
    seq_state_e       cur_state;
    logic             stall;
    logic             pipe_en;
    logic             accept;
    logic             res_load;

    logic [17:0]      a_q;
    logic [17:0]      b_q;
    logic [17:0]      d_q;
    logic [47:0]      c_q;
    logic [7:0]       opm_q;
    logic             vld_q;
    logic [TAG_W-1:0] tag_q;

    logic [ALIGN_W-1:0] align_out;
    logic [PIPE_W-1:0]  pipe_out;

    logic             res_valid_q;
    logic [47:0]      res_p_q;
    logic             res_carry_q;
    logic [TAG_W-1:0] res_tag_q;

    // A held result that the consumer refuses freezes the whole datapath
    assign stall = res_valid_q & ~res_ready;

    // Effective state: RUN/STALL follow res_ready combinationally
    always_comb begin
        cur_state = ST_RUN;
        if (state_q == ST_INIT) begin
            cur_state = ST_INIT;
        end else if (stall) begin
            cur_state = ST_STALL;
        end
    end

    // One INIT cycle after reset, then follow run/stall each cycle
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_INIT;
        end else begin
            case (cur_state)
                ST_INIT:  state_q <= ST_RUN;
                ST_STALL: state_q <= ST_STALL;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign pipe_en     = (cur_state == ST_RUN);
    assign cmd_ready   = pipe_en;
    assign dsp_CE      = pipe_en;
    assign dsp_RST     = (state_q == ST_INIT);
    assign dsp_CARRYIN = 1'b0;
    assign accept      = cmd_valid & cmd_ready;

    // Launch stage: data pins hold across bubbles, opmode falls back to hold
    always_ff @(posedge clk) begin
        if (RST) begin
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            c_q   <= '0;
            opm_q <= '0;
            vld_q <= 1'b0;
            tag_q <= '0;
        end else if (pipe_en) begin
            vld_q <= accept;
            if (accept) begin
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                d_q   <= cmd_d;
                c_q   <= cmd_c;
                tag_q <= cmd_tag;
                opm_q <= op_to_opmode(cmd_op, cmd_sub);
            end else begin
                opm_q <= OPMODE_BUBBLE;
            end
        end
    end

    assign dsp_A = a_q;
    assign dsp_B = b_q;
    assign dsp_D = d_q;

    // Opmode and C trail the operands so they meet M at the post-adder
    generate
        if (ALIGN_DLY > 0) begin : g_align_dly
            dsp_seq_delay #(
                .WIDTH (ALIGN_W),
                .DEPTH (ALIGN_DLY)
            ) u_align (
                .clk  (clk),
                .rst  (RST),
                .en_i (pipe_en),
                .d_i  ({opm_q, c_q}),
                .q_o  (align_out)
            );
        end else begin : g_align_none
            assign align_out = {opm_q, c_q};
        end
    endgenerate

    assign dsp_opmode = align_out[ALIGN_W-1 -: 8];
    assign dsp_C      = align_out[47:0];

    // Valid/tag ride alongside the DSP registers and emerge with P
    dsp_seq_delay #(
        .WIDTH (PIPE_W),
        .DEPTH (LAT)
    ) u_pipe (
        .clk  (clk),
        .rst  (RST),
        .en_i (pipe_en),
        .d_i  ({vld_q, tag_q}),
        .q_o  (pipe_out)
    );

    assign res_load = pipe_out[PIPE_W-1] & (~res_valid_q | res_ready);

    // Result holding register; a new capture may replace an accepted result
    always_ff @(posedge clk) begin
        if (RST) begin
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            res_carry_q <= 1'b0;
            res_tag_q   <= '0;
        end else if (res_load) begin
            res_valid_q <= 1'b1;
            res_p_q     <= dsp_P;
            res_carry_q <= dsp_CARRYOUT;
            res_tag_q   <= pipe_out[TAG_W-1:0];
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_carry = res_carry_q;
    assign res_tag   = res_tag_q;

`ifdef DSP_SEQ_STATS_EN
    logic [15:0] stat_results_q;
    logic [15:0] stat_stalls_q;

    // Saturating counters of delivered results and frozen cycles
    always_ff @(posedge clk) begin
        if (RST) begin
            stat_results_q <= '0;
            stat_stalls_q  <= '0;
        end else begin
            if (res_valid_q && res_ready && (stat_results_q != 16'hFFFF)) begin
                stat_results_q <= stat_results_q + 16'd1;
            end
            if ((cur_state == ST_STALL) && (stat_stalls_q != 16'hFFFF)) begin
                stat_stalls_q <= stat_stalls_q + 16'd1;
            end
        end
    end

    assign stat_results = stat_results_q;
    assign stat_stalls  = stat_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_cmd_sequencer
// Description : Directed self-checking bench for dsp_cmd_sequencer with a
//               behavioural DSP slice (A1/B1, M, P registers, registered
//               opmode/C) connected to the dsp_* pins.
// Options     : DSP_SEQ_STATS_EN enables the statistics checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dsp_cmd_sequencer;

    localparam logic [1:0] T_MUL    = 2'd0;
    localparam logic [1:0] T_MAC    = 2'd1;
    localparam logic [1:0] T_PREMUL = 2'd2;
    localparam logic [1:0] T_MULADD = 2'd3;

    logic        clk = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_sub;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic [3:0]  cmd_tag;
    logic [17:0] dsp_A, dsp_B, dsp_D;
    logic [47:0] dsp_C;
    logic [7:0]  dsp_opmode;
    logic        dsp_CARRYIN, dsp_CE, dsp_RST;
    logic [47:0] dsp_P;
    logic        dsp_CARRYOUT;
    logic        res_valid, res_ready, res_carry;
    logic [47:0] res_p;
    logic [3:0]  res_tag;
`ifdef DSP_SEQ_STATS_EN
    logic [15:0] stat_results, stat_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    logic [47:0] col_p   [8];
    logic [3:0]  col_tag [8];
    int          col_n;

    always #5 clk = ~clk;

    dsp_cmd_sequencer #(
        .LAT       (3),
        .ALIGN_DLY (1),
        .TAG_W     (4)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_sub      (cmd_sub),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_d        (cmd_d),
        .cmd_c        (cmd_c),
        .cmd_tag      (cmd_tag),
        .dsp_A        (dsp_A),
        .dsp_B        (dsp_B),
        .dsp_D        (dsp_D),
        .dsp_C        (dsp_C),
        .dsp_opmode   (dsp_opmode),
        .dsp_CARRYIN  (dsp_CARRYIN),
        .dsp_CE       (dsp_CE),
        .dsp_RST      (dsp_RST),
        .dsp_P        (dsp_P),
        .dsp_CARRYOUT (dsp_CARRYOUT),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_p        (res_p),
        .res_carry    (res_carry),
        .res_tag      (res_tag)
`ifdef DSP_SEQ_STATS_EN
       ,.stat_results (stat_results),
        .stat_stalls  (stat_stalls)
`endif
    );

    // ---------------- behavioural DSP slice ----------------
    logic [17:0] a1_q, b1_q, d1_q;
    logic [47:0] m_q, c_r, p_q;
    logic [7:0]  opr_q;
    logic        cy_q;
    logic [18:0] pre_sum;
    logic [47:0] mult, xv, zv;
    logic [48:0] post;

    always_comb begin
        pre_sum = dsp_opmode[4] ? ({1'b0, d1_q} + {1'b0, b1_q}) : {1'b0, b1_q};
        mult    = {29'd0, pre_sum} * {30'd0, a1_q};
        xv      = (opr_q[1:0] == 2'b01) ? m_q : 48'd0;
        case (opr_q[3:2])
            2'b10:   zv = p_q;
            2'b11:   zv = c_r;
            default: zv = 48'd0;
        endcase
        post = opr_q[7] ? ({1'b0, zv} - {1'b0, xv}) : ({1'b0, zv} + {1'b0, xv});
    end

    always @(posedge clk) begin
        if (dsp_RST === 1'b1) begin
            a1_q <= '0; b1_q <= '0; d1_q <= '0;
            m_q <= '0; c_r <= '0; p_q <= '0; opr_q <= '0; cy_q <= 1'b0;
        end else if (dsp_CE === 1'b1) begin
            a1_q  <= dsp_A;
            b1_q  <= dsp_B;
            d1_q  <= dsp_D;
            m_q   <= mult;
            opr_q <= dsp_opmode;
            c_r   <= dsp_C;
            p_q   <= post[47:0];
            cy_q  <= post[48];
        end
    end

    assign dsp_P        = p_q;
    assign dsp_CARRYOUT = cy_q;

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic sub, input logic [17:0] a,
                            input logic [17:0] b, input logic [17:0] d,
                            input logic [47:0] c, input logic [3:0] tag);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sub   = sub;
        cmd_a     = a;
        cmd_b     = b;
        cmd_d     = d;
        cmd_c     = c;
        cmd_tag   = tag;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_cmd: tag %0d not accepted within 40 cycles", tag);
        end
    endtask

    task automatic wait_res(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_res: res_valid not seen within %0d cycles", budget);
        end
    endtask

    task automatic collect(input int n, input int budget);
        col_n = 0;
        for (int i = 0; i < budget && col_n < n; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                col_p[col_n]   = res_p;
                col_tag[col_n] = res_tag;
                col_n++;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || dsp_RST !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: cmd_ready=%b dsp_RST=%b res_valid=%b, required 0 1 0",
                     cmd_ready, dsp_RST, res_valid);
        end
        checks++;
        if (dsp_opmode !== 8'h00 || dsp_A !== 18'd0 || res_p !== 48'd0) begin
            failures++;
            $display("FAIL reset_values: opmode=%h A=%h res_p=%h, required 00 0 0",
                     dsp_opmode, dsp_A, res_p);
        end
        @(posedge clk);
        #1;
        RST = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || dsp_RST !== 1'b1 || dsp_CE !== 1'b0) begin
            failures++;
            $display("FAIL init_cycle: cmd_ready=%b dsp_RST=%b dsp_CE=%b, required 0 1 0",
                     cmd_ready, dsp_RST, dsp_CE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || dsp_RST !== 1'b0 || dsp_CE !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL run_entry: cmd_ready=%b dsp_RST=%b dsp_CE=%b res_valid=%b, required 1 0 1 0",
                     cmd_ready, dsp_RST, dsp_CE, res_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dsp_opmode !== 8'h08) begin
            failures++;
            $display("FAIL idle_bubble: opmode=%h, required 08", dsp_opmode);
        end
    endtask

    task automatic test_mul();
        send_cmd(T_MUL, 1'b0, 18'd20, 18'd10, 18'd0, 48'd0, 4'd1);
        checks++;
        if (dsp_A !== 18'd20 || dsp_B !== 18'd10 || dsp_opmode !== 8'h08) begin
            failures++;
            $display("FAIL mul_launch: A=%0d B=%0d opmode=%h, required 20 10 08", dsp_A, dsp_B, dsp_opmode);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dsp_opmode !== 8'h01 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_align: opmode=%h res_valid=%b, required 01 0", dsp_opmode, res_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_early: res_valid=%b at k+3, required 0", res_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_p !== 48'hC8 || res_tag !== 4'd1 || res_carry !== 1'b0) begin
            failures++;
            $display("FAIL mul_result: valid=%b p=%h tag=%0d carry=%b, required 1 c8 1 0",
                     res_valid, res_p, res_tag, res_carry);
        end
        checks++;
        if (dsp_A !== 18'd20 || dsp_opmode !== 8'h08) begin
            failures++;
            $display("FAIL mul_hold: A=%0d opmode=%h, required 20 08", dsp_A, dsp_opmode);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_clear: res_valid=%b after accept, required 0", res_valid);
        end
    endtask

    task automatic test_premul();
        send_cmd(T_PREMUL, 1'b0, 18'd20, 18'd10, 18'd25, 48'd0, 4'd2);
        wait_res(10);
        checks++;
        if (res_p !== 48'h2BC || res_tag !== 4'd2 || res_carry !== 1'b0) begin
            failures++;
            $display("FAIL premul_result: p=%h tag=%0d carry=%b, required 2bc 2 0", res_p, res_tag, res_carry);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_muladd_sub();
        send_cmd(T_MULADD, 1'b1, 18'd20, 18'd10, 18'd0, 48'd350, 4'd3);
        @(posedge clk);
        #1;
        checks++;
        if (dsp_opmode !== 8'h8D || dsp_C !== 48'd350) begin
            failures++;
            $display("FAIL muladd_align: opmode=%h C=%0d, required 8d 350", dsp_opmode, dsp_C);
        end
        wait_res(10);
        checks++;
        if (res_p !== 48'h96 || res_tag !== 4'd3 || res_carry !== 1'b0) begin
            failures++;
            $display("FAIL muladd_result: p=%h tag=%0d carry=%b, required 96 3 0", res_p, res_tag, res_carry);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        logic seen;
        send_cmd(T_MUL, 1'b0, 18'd7, 18'd3, 18'd0, 48'd0, 4'd5);
        RST = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dsp_opmode !== 8'h00 || dsp_A !== 18'd0 || dsp_RST !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_values: opmode=%h A=%0d dsp_RST=%b res_valid=%b, required 00 0 1 0",
                     dsp_opmode, dsp_A, dsp_RST, res_valid);
        end
        RST  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard: in-flight result appeared=%b, required 0", seen);
        end
        send_cmd(T_MAC, 1'b0, 18'd2, 18'd2, 18'd0, 48'd0, 4'd6);
        wait_res(10);
        checks++;
        if (res_p !== 48'd4 || res_tag !== 4'd6) begin
            failures++;
            $display("FAIL midrst_acc: p=%0d tag=%0d, required 4 6", res_p, res_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_mac();
        logic [47:0] exp_p [4];
        exp_p[0] = 48'd30; exp_p[1] = 48'd60; exp_p[2] = 48'd90; exp_p[3] = 48'd91;
        do_reset();
        fork
            begin
                send_cmd(T_MAC, 1'b0, 18'd5, 18'd6, 18'd0, 48'd0, 4'd1);
                send_cmd(T_MAC, 1'b0, 18'd5, 18'd6, 18'd0, 48'd0, 4'd2);
                send_cmd(T_MAC, 1'b0, 18'd5, 18'd6, 18'd0, 48'd0, 4'd3);
                repeat (2) @(posedge clk);
                #1;
                send_cmd(T_MAC, 1'b0, 18'd1, 18'd1, 18'd0, 48'd0, 4'd4);
            end
            collect(4, 60);
        join
        checks++;
        if (col_n !== 4) begin
            failures++;
            $display("FAIL mac_count: got %0d results, required 4", col_n);
        end
        for (int i = 0; i < 4 && i < col_n; i++) begin
            checks++;
            if (col_p[i] !== exp_p[i] || col_tag[i] !== 4'(i + 1)) begin
                failures++;
                $display("FAIL mac_result[%0d]: p=%0d tag=%0d, required %0d %0d",
                         i, col_p[i], col_tag[i], exp_p[i], i + 1);
            end
        end
    endtask

    task automatic test_stall();
        logic [47:0] exp_p [6];
        logic        found;
        exp_p[0] = 48'd33; exp_p[1] = 48'd48; exp_p[2] = 48'd65;
        exp_p[3] = 48'd84; exp_p[4] = 48'd105; exp_p[5] = 48'd128;
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_cmd(T_MUL, 1'b0, 18'(i + 3), 18'(i + 11), 18'd0, 48'd0, 4'(i + 1));
                end
            end
            begin
                found = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    if (res_valid === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (!found) begin
                    checks++;
                    failures++;
                    $display("FAIL stall_start: no result within 50 cycles");
                end
                res_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    checks++;
                    if (dsp_CE !== 1'b0 || cmd_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_freeze[%0d]: dsp_CE=%b cmd_ready=%b, required 0 0",
                                 i, dsp_CE, cmd_ready);
                    end
                    @(posedge clk);
                    #1;
                end
                res_ready = 1'b1;
                #1;
                checks++;
                if (dsp_CE !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_release: dsp_CE=%b, required 1", dsp_CE);
                end
            end
            collect(6, 100);
        join
        checks++;
        if (col_n !== 6) begin
            failures++;
            $display("FAIL stall_count: got %0d results, required 6", col_n);
        end
        for (int i = 0; i < 6 && i < col_n; i++) begin
            checks++;
            if (col_p[i] !== exp_p[i] || col_tag[i] !== 4'(i + 1)) begin
                failures++;
                $display("FAIL stall_result[%0d]: p=%0d tag=%0d, required %0d %0d",
                         i, col_p[i], col_tag[i], exp_p[i], i + 1);
            end
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_extra: res_valid=%b after stream drained, required 0", res_valid);
        end
`ifdef DSP_SEQ_STATS_EN
        checks++;
        if (stat_stalls !== 16'd5 || stat_results !== 16'd6) begin
            failures++;
            $display("FAIL stats: stalls=%0d results=%0d, required 5 6", stat_stalls, stat_results);
        end
`endif
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_sub   = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_d     = '0;
        cmd_c     = '0;
        cmd_tag   = '0;
        res_ready = 1'b1;
        test_reset();
        test_mul();
        test_premul();
        test_muladd_sub();
        test_reset_midstream();
        test_back_to_back_mac();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
